// File: rtl/pac_dir_scheduler.sv
// rtl/pac_dir_scheduler.sv - Button-to-move scheduler with maze legality handshake
// Optional per-button debounce is built when PAC_DIR_DEBOUNCE_EN is defined.
module pac_dir_scheduler #(
    parameter int TICK_DIV  = 1000000,
    parameter int DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btns,
    input  logic       run,
    output logic       chk_req,
    output logic [1:0] chk_dir,
    input  logic       chk_ack,
    input  logic       chk_blocked,
    output logic       step,
    output logic [1:0] step_dir,
    output logic       moving,
    output logic       overrun
);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, CHK_PEND, CHK_CUR, STEP} state_t;

    state_t          state, state_next;
    logic [3:0]      sync1, sync2, cond;
    logic            press_valid, prev_valid, new_press;
    logic [1:0]      press_dir, prev_dir;
    logic [TW-1:0]   tick_cnt;
    logic            tick, tick_evt;
    logic            pend_valid, cur_valid;
    logic [1:0]      pend_dir, cur_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btns;
            sync2 <= sync1;
        end
    end

`ifdef PAC_DIR_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES);
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic          lvl;
        // The first differing sample counts as one; a single equal sample restarts the run.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DW'(DB_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign cond[i] = lvl;
    end
`else
    assign cond = sync2;
`endif

    always_comb begin
        press_valid = 1'b1;
        press_dir   = 2'd0;
        case (cond)
            4'b0001: press_dir = 2'd0;
            4'b0010: press_dir = 2'd1;
            4'b0100: press_dir = 2'd2;
            4'b1000: press_dir = 2'd3;
            default: press_valid = 1'b0;
        endcase
    end

    assign new_press = press_valid && (!prev_valid || (prev_dir != press_dir));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_dir   <= 2'd0;
        end else begin
            prev_valid <= press_valid;
            prev_dir   <= press_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (!run) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    assign tick_evt = tick && run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tick_evt) begin
                    if (pend_valid)     state_next = CHK_PEND;
                    else if (cur_valid) state_next = CHK_CUR;
                end
            end
            CHK_PEND: begin
                if (chk_ack) begin
                    if (!chk_blocked)   state_next = STEP;
                    else if (cur_valid) state_next = CHK_CUR;
                    else                state_next = IDLE;
                end
            end
            CHK_CUR: begin
                if (chk_ack) state_next = chk_blocked ? IDLE : STEP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_dir    <= 2'd0;
            cur_dir    <= 2'd0;
            cur_valid  <= 1'b0;
            pend_dir   <= 2'd0;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (tick_evt && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick_evt && (pend_valid || cur_valid))
                        chk_dir <= pend_valid ? pend_dir : cur_dir;
                end
                CHK_PEND: begin
                    // cur_dir takes the latched query, not pend_dir, which a racing press may have changed.
                    if (chk_ack && !chk_blocked) begin
                        cur_dir   <= chk_dir;
                        cur_valid <= 1'b1;
                    end else if (chk_ack && cur_valid) begin
                        chk_dir <= cur_dir;
                    end
                end
                CHK_CUR: begin
                    if (chk_ack && chk_blocked) cur_valid <= 1'b0;
                end
                default: ;
            endcase
            if (new_press) begin
                pend_valid <= 1'b1;
                pend_dir   <= press_dir;
            end else if (state == CHK_PEND && chk_ack && !chk_blocked) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign chk_req  = (state == CHK_PEND) || (state == CHK_CUR);
    assign step     = (state == STEP);
    assign step_dir = step ? cur_dir : 2'd0;
    assign moving   = cur_valid;

endmodule

// File: tb/tb_pac_dir_scheduler.sv
// tb/tb_pac_dir_scheduler.sv - Directed and model-checked random bench for pac_dir_scheduler
`timescale 1ns/1ps
module tb_pac_dir_scheduler;
    localparam int TICK_DIV  = 8;
    localparam int DB_CYCLES = 4;
`ifdef PAC_DIR_DEBOUNCE_EN
    localparam int SETTLE    = DB_CYCLES + 6;
    localparam int PRESS_LAT = DB_CYCLES + 2;
`else
    localparam int SETTLE    = 4;
    localparam int PRESS_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n, run, chk_ack, chk_blocked;
    logic [3:0] btns;
    logic       chk_req, step, moving, overrun;
    logic [1:0] chk_dir, step_dir;

    int errors = 0;
    int checks = 0;

    pac_dir_scheduler #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .btns(btns), .run(run),
        .chk_req(chk_req), .chk_dir(chk_dir), .chk_ack(chk_ack), .chk_blocked(chk_blocked),
        .step(step), .step_dir(step_dir), .moving(moving), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (chk_req) seen = 1'b1;
        end
    endtask

    task automatic do_ack(input bit blk);
        chk_ack = 1'b1;
        chk_blocked = blk;
        @(negedge clk);
        chk_ack = 1'b0;
        chk_blocked = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0; run = 1'b0; btns = 4'b0; chk_ack = 1'b0; chk_blocked = 1'b0;
        cycles(2);
        obs = {chk_req, chk_dir, step, step_dir, moving, overrun};
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", obs); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_dir();
        bit seen;
        int t;
        run = 1'b0; btns = 4'b0100; cycles(SETTLE); run = 1'b1;
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL first_req: got %0d expected 1", seen); end
        checks++;
        if (chk_dir !== 2'd2) begin errors++; $display("FAIL first_chk_dir: got %0d expected 2", chk_dir); end
        do_ack(1'b0);
        checks++;
        if ({step, step_dir, moving} !== 4'b1101) begin
            errors++; $display("FAIL first_step: got step=%b dir=%0d moving=%b expected 1 2 1", step, step_dir, moving);
        end
        for (int k = 0; k < 3; k++) begin
            t = 0; seen = 1'b0;
            while (!seen && t < 3 * TICK_DIV) begin
                @(negedge clk); t++;
                if (chk_req) seen = 1'b1;
            end
            do_ack(1'b0); t++;
            checks++;
            if (step !== 1'b1 || step_dir !== 2'd2 || t != TICK_DIV) begin
                errors++; $display("FAIL step_period: got step=%b dir=%0d period=%0d expected 1 2 %0d", step, step_dir, t, TICK_DIV);
            end
        end
    endtask

    task automatic test_blocked_pend();
        bit seen;
        run = 1'b0; btns = 4'b0001; cycles(SETTLE); run = 1'b1;
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd0) begin errors++; $display("FAIL pend_query: got req=%0d dir=%0d expected 1 0", seen, chk_dir); end
        do_ack(1'b1);
        checks++;
        if (chk_req !== 1'b1 || chk_dir !== 2'd2) begin errors++; $display("FAIL cur_after_block: got req=%b dir=%0d expected 1 2", chk_req, chk_dir); end
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || step_dir !== 2'd2) begin errors++; $display("FAIL cur_step: got step=%b dir=%0d expected 1 2", step, step_dir); end
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd0) begin errors++; $display("FAIL pend_kept: got req=%0d dir=%0d expected 1 0", seen, chk_dir); end
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || step_dir !== 2'd0) begin errors++; $display("FAIL pend_step: got step=%b dir=%0d expected 1 0", step, step_dir); end
    endtask

    task automatic test_multi();
        bit seen;
        run = 1'b0; btns = 4'b0011; cycles(SETTLE); run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_req(TICK_DIV + 6, seen);
            checks++;
            if (!seen || chk_dir !== 2'd0) begin errors++; $display("FAIL multi_ignored: got req=%0d dir=%0d expected 1 0", seen, chk_dir); end
            do_ack(1'b0);
            checks++;
            if (step !== 1'b1 || step_dir !== 2'd0) begin errors++; $display("FAIL multi_step: got step=%b dir=%0d expected 1 0", step, step_dir); end
        end
    endtask

    task automatic test_ack_ignore();
        bit seen;
        chk_ack = 1'b1; chk_blocked = 1'b1;
        @(negedge clk);
        chk_ack = 1'b0; chk_blocked = 1'b0;
        checks++;
        if (moving !== 1'b1 || chk_req !== 1'b0) begin errors++; $display("FAIL idle_ack: got moving=%b req=%b expected 1 0", moving, chk_req); end
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd0) begin errors++; $display("FAIL idle_ack_query: got req=%0d dir=%0d expected 1 0", seen, chk_dir); end
        do_ack(1'b0);
    endtask

    task automatic test_overrun();
        bit seen;
        bit stable;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
        wait_req(TICK_DIV + 6, seen);
        stable = seen;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (chk_req !== 1'b1 || chk_dir !== 2'd0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL held_query: got stable=%0d expected 1", stable); end
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got step=%b overrun=%b expected 1 1", step, overrun); end
    endtask

    task automatic test_coincide();
        bit seen;
        run = 1'b0; btns = 4'b0100; cycles(SETTLE); run = 1'b1;
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd2) begin errors++; $display("FAIL race_query: got req=%0d dir=%0d expected 1 2", seen, chk_dir); end
        btns = 4'b1000;
        cycles(PRESS_LAT);
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || step_dir !== 2'd2) begin errors++; $display("FAIL race_step: got step=%b dir=%0d expected 1 2", step, step_dir); end
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd3) begin errors++; $display("FAIL race_pend: got req=%0d dir=%0d expected 1 3", seen, chk_dir); end
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || step_dir !== 2'd3) begin errors++; $display("FAIL race_step2: got step=%b dir=%0d expected 1 3", step, step_dir); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit quiet;
        logic [8:0] obs;
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL mid_req: got %0d expected 1", seen); end
        #2 rst_n = 1'b0;
        #1 obs = {chk_req, chk_dir, step, step_dir, moving, overrun};
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL async_reset: got %b expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < TICK_DIV; i++) begin
            @(negedge clk);
            if (chk_req) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL req_before_tick: got quiet=%0d expected 1", quiet); end
        wait_req(6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd3) begin errors++; $display("FAIL req_after_reset: got req=%0d dir=%0d expected 1 3", seen, chk_dir); end
        do_ack(1'b0);
        checks++;
        if (step !== 1'b1 || step_dir !== 2'd3) begin errors++; $display("FAIL step_after_reset: got step=%b dir=%0d expected 1 3", step, step_dir); end
    endtask

    task automatic test_random();
        bit m_pend_v, m_cur_v, m_prev_v;
        int m_pend_d, m_cur_d, m_prev_d;
        bit seen, quiet, done, blk, exp_step, pv;
        int phase, exp_dir, kind, b1, b2, pd;
        logic [3:0] pat;
        rst_n = 1'b0; run = 1'b0; btns = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pend_v = 0; m_cur_v = 0; m_prev_v = 0;
        m_pend_d = 0; m_cur_d = 0; m_prev_d = 0;
        pat = 4'b0;
        for (int it = 0; it < 40; it++) begin
            run = 1'b0;
            kind = $urandom_range(0, 4);
            b1 = $urandom_range(0, 3);
            b2 = (b1 + $urandom_range(1, 3)) % 4;
            if (kind == 0)      pat = 4'b0;
            else if (kind <= 2) pat = 4'(1 << b1);
            else if (kind == 3) pat = 4'((1 << b1) | (1 << b2));
            btns = pat;
            pv = ($countones(pat) == 1);
            pd = 0;
            for (int b = 0; b < 4; b++) if (pat[b]) pd = b;
            if (pv && (!m_prev_v || m_prev_d != pd)) begin
                m_pend_v = 1; m_pend_d = pd;
            end
            m_prev_v = pv; m_prev_d = pd;
            cycles(SETTLE);
            run = 1'b1;
            phase = m_pend_v ? 1 : (m_cur_v ? 2 : 0);
            if (phase == 0) begin
                quiet = 1'b1;
                for (int i = 0; i < TICK_DIV + 4; i++) begin
                    @(negedge clk);
                    if (chk_req) quiet = 1'b0;
                end
                checks++;
                if (quiet !== 1'b1) begin errors++; $display("FAIL rand_no_query it=%0d: got query expected none", it); end
            end else begin
                wait_req(TICK_DIV + 4, seen);
                checks++;
                if (seen !== 1'b1) begin errors++; $display("FAIL rand_query_seen it=%0d: got 0 expected 1", it); break; end
                done = 0; exp_step = 0;
                while (!done) begin
                    exp_dir = (phase == 1) ? m_pend_d : m_cur_d;
                    checks++;
                    if (chk_req !== 1'b1 || chk_dir !== 2'(exp_dir)) begin
                        errors++; $display("FAIL rand_query it=%0d: got req=%b dir=%0d expected 1 %0d", it, chk_req, chk_dir, exp_dir);
                    end
                    blk = ($urandom_range(0, 2) == 0);
                    cycles($urandom_range(0, 2));
                    do_ack(blk);
                    if (phase == 1) begin
                        if (!blk) begin
                            m_cur_d = m_pend_d; m_cur_v = 1; m_pend_v = 0; exp_step = 1; done = 1;
                        end else if (m_cur_v) begin
                            phase = 2;
                        end else begin
                            exp_step = 0; done = 1;
                        end
                    end else begin
                        if (blk) m_cur_v = 0;
                        exp_step = !blk; done = 1;
                    end
                end
                checks++;
                if (step !== exp_step || (exp_step && step_dir !== 2'(m_cur_d))) begin
                    errors++; $display("FAIL rand_step it=%0d: got step=%b dir=%0d expected %0d %0d", it, step, step_dir, exp_step, m_cur_d);
                end
            end
            checks++;
            if (moving !== m_cur_v) begin errors++; $display("FAIL rand_moving it=%0d: got %b expected %0d", it, moving, m_cur_v); end
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
    endtask

`ifdef PAC_DIR_DEBOUNCE_EN
    task automatic test_debounce();
        bit seen;
        bit quiet;
        rst_n = 1'b0; run = 1'b0; btns = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        btns = 4'b0010; cycles(3); btns = 4'b0; cycles(10);
        run = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < TICK_DIV + 4; i++) begin
            @(negedge clk);
            if (chk_req) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL glitch_filtered: got query expected none"); end
        run = 1'b0;
        btns = 4'b0010; cycles(6); btns = 4'b0; cycles(10);
        run = 1'b1;
        wait_req(TICK_DIV + 6, seen);
        checks++;
        if (!seen || chk_dir !== 2'd1) begin errors++; $display("FAIL debounced_press: got req=%0d dir=%0d expected 1 1", seen, chk_dir); end
        do_ack(1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_dir();
        test_blocked_pend();
        test_multi();
        test_ack_ignore();
        test_overrun();
        test_coincide();
        test_reset_mid();
        test_random();
`ifdef PAC_DIR_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
